// File: rtl/spi_pkg.sv
// Shared command encoding and widths for the SPI slave / RAM controller pair.
package spi_pkg;

    localparam int CMD_W  = 10;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

endpackage

// File: rtl/spi_ram_ctrl_if.sv
// Command / read-data link between the SPI slave (master side) and the RAM controller.
interface spi_ram_ctrl_if;
    import spi_pkg::*;

    logic [CMD_W-1:0]  din;
    logic              rx_valid;
    logic [DATA_W-1:0] dout;
    logic              tx_valid;
    logic              err;

    modport master (output din, rx_valid, input dout, tx_valid, err);
    modport slave  (input din, rx_valid, output dout, tx_valid, err);
endinterface

// File: rtl/spi_ram_mem.sv
// MEM_DEPTH x DATA_W single-port array: synchronous write, registered read.
module spi_ram_mem
    import spi_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [ADDR_SIZE-1:0] waddr,
    input  logic [DATA_W-1:0]    wdata,
    input  logic                 re,
    input  logic [ADDR_SIZE-1:0] raddr,
    output logic [DATA_W-1:0]    rdata
);
    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr[AW-1:0]] <= wdata;
    end

    // The read register doubles as the controller's dout, so it alone is reset.
    always_ff @(posedge clk) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[raddr[AW-1:0]];
    end

    // Pointers never exceed MEM_DEPTH-1, so the upper bits carry no information.
    generate
        if (AW < ADDR_SIZE) begin : g_hi
            logic unused_hi;
            assign unused_hi = ^{waddr[ADDR_SIZE-1:AW], raddr[ADDR_SIZE-1:AW]};
        end
    endgenerate
endmodule

// File: rtl/spi_ram_ctrl.sv
// Command decoder for the SPI-attached RAM: address/data pointers, read return, error pulse.
module spi_ram_ctrl
    import spi_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic          clk,
    input  logic          rst,
    spi_ram_ctrl_if.slave bus
);
    localparam logic [ADDR_SIZE:0]   DEPTH_X = (ADDR_SIZE+1)'(MEM_DEPTH);
    localparam logic [ADDR_SIZE-1:0] LAST    = ADDR_SIZE'(MEM_DEPTH - 1);

    cmd_e                 op;
    logic [DATA_W-1:0]    payload;
    logic                 addr_ok;
    logic [ADDR_SIZE-1:0] wr_ptr, rd_ptr, wr_ptr_nx, rd_ptr_nx;
    logic                 wr_vld, rd_vld, wr_vld_nx, rd_vld_nx;
    logic                 we, re, err_nx, tx_valid_q, err_q;

    assign op      = cmd_e'(bus.din[CMD_W-1:DATA_W]);
    assign payload = bus.din[DATA_W-1:0];
    assign addr_ok = {1'b0, payload} < DEPTH_X;

    function automatic logic [ADDR_SIZE-1:0] next_ptr(input logic [ADDR_SIZE-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wr_ptr_nx = wr_ptr;
        rd_ptr_nx = rd_ptr;
        wr_vld_nx = wr_vld;
        rd_vld_nx = rd_vld;
        we        = 1'b0;
        re        = 1'b0;
        err_nx    = 1'b0;
        // Gating on rst keeps a command in the reset cycle from touching memory.
        if (bus.rx_valid && !rst) begin
            unique case (op)
                CMD_WR_ADDR: if (addr_ok) begin
                    wr_ptr_nx = payload;
                    wr_vld_nx = 1'b1;
                end else err_nx = 1'b1;
                CMD_WR_DATA: if (wr_vld) begin
                    we        = 1'b1;
                    wr_ptr_nx = next_ptr(wr_ptr);
                end else err_nx = 1'b1;
                CMD_RD_ADDR: if (addr_ok) begin
                    rd_ptr_nx = payload;
                    rd_vld_nx = 1'b1;
                end else err_nx = 1'b1;
                CMD_RD_DATA: if (rd_vld) begin
                    re        = 1'b1;
                    rd_ptr_nx = next_ptr(rd_ptr);
                end else err_nx = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            wr_vld     <= 1'b0;
            rd_vld     <= 1'b0;
            tx_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr_nx;
            rd_ptr     <= rd_ptr_nx;
            wr_vld     <= wr_vld_nx;
            rd_vld     <= rd_vld_nx;
            tx_valid_q <= re;
            err_q      <= err_nx;
        end
    end

    spi_ram_mem #(
        .MEM_DEPTH(MEM_DEPTH),
        .ADDR_SIZE(ADDR_SIZE)
    ) u_mem (
        .clk  (clk),
        .rst  (rst),
        .we   (we),
        .waddr(wr_ptr),
        .wdata(payload),
        .re   (re),
        .raddr(rd_ptr),
        .rdata(bus.dout)
    );

    assign bus.tx_valid = tx_valid_q;
    assign bus.err      = err_q;
endmodule

// File: doc/spi_ram_ctrl.md
Name: spi_ram_ctrl

Overview:
Command-decoding single-port RAM that sits directly downstream of the SPI slave.
- Consumes the slave's 10-bit parallel word plus its valid strobe.
- Executes write-address / write-data / read-address / read-data commands.
- Returns read bytes to the slave's tx_data/tx_valid inputs for serialisation on MISO.
- Auto-increments both address pointers so consecutive data transfers stream through memory.

Parameters:
MEM_DEPTH, 256, number of 8-bit words in the array (2..256)
ADDR_SIZE, 8, address pointer width; fixed equal to the payload width din[7:0]

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
din  input  10  command word from SPI slave rx_data; [9:8] = opcode, [7:0] = payload
rx_valid  input  1  one-cycle strobe: din holds a complete command this cycle
dout  output  8  read data to SPI slave tx_data
tx_valid  output  1  one-cycle strobe: dout valid, slave loads its shift register
err  output  1  one-cycle pulse: command rejected

Behaviour:
Interface:
- One clock (clk); reset rst is synchronous and active-high.

Reset values:
- dout = 0, tx_valid = 0, err = 0, wr_ptr = 0, rd_ptr = 0, wr_vld = 0, rd_vld = 0.
- Memory contents are NOT reset.

Command sampling:
- A command is sampled only on a rising edge where rx_valid = 1; when rx_valid = 0, nothing changes except that tx_valid and err drop to 0.
- Opcode 00 (WR_ADDR): if payload < MEM_DEPTH, wr_ptr <= payload and wr_vld <= 1. Otherwise err pulses and wr_ptr/wr_vld are unchanged.
- Opcode 01 (WR_DATA): if wr_vld = 1, mem[wr_ptr] <= payload and wr_ptr <= (wr_ptr == MEM_DEPTH-1) ? 0 : wr_ptr+1. Otherwise err pulses and memory is untouched.
- Opcode 10 (RD_ADDR): if payload < MEM_DEPTH, rd_ptr <= payload and rd_vld <= 1. Otherwise err pulses.
- Opcode 11 (RD_DATA): if rd_vld = 1, dout <= mem[rd_ptr], tx_valid <= 1, and rd_ptr increments with the same wrap rule. Otherwise err pulses and tx_valid stays 0.

Latency and output timing:
- RD_DATA sampled at edge k gives dout/tx_valid visible during cycle k+1 (1-cycle latency).
- tx_valid is high for exactly one cycle per accepted RD_DATA.
- dout holds its last read value until the next accepted RD_DATA.
- err is high for exactly one cycle per rejected command and is never asserted together with a write or pointer update.

Boundary conditions:
- rx_valid high on consecutive cycles: each cycle is an independent command, with no bubbles required. Back-to-back RD_DATA gives back-to-back tx_valid pulses with consecutive addresses.
- WR_DATA to address A at edge k followed by RD_DATA of A at edge k+1: returns the new data (read sees the committed write).
- Same-edge read and write are impossible; there is one command per edge.
- Pointer wrap: MEM_DEPTH-1 goes to 0 for both pointers; wr_vld/rd_vld remain 1 after wrapping.
- rst asserted mid-stream: a pending tx_valid is dropped in the reset cycle, pointers and valid flags clear, and subsequent WR_DATA/RD_DATA are rejected until a new address command arrives.
- A command presented on a cycle with rst = 1 is ignored.

Decomposition:
Shared package spi_pkg:
- Opcode constants CMD_WR_ADDR = 2'b00, CMD_WR_DATA = 2'b01, CMD_RD_ADDR = 2'b10, CMD_RD_DATA = 2'b11.
- Width constants CMD_W = 10, DATA_W = 8.
- The SPI slave reuses these constants for its command decode.

Sub-module spi_ram_mem:
- Parameterised MEM_DEPTH x 8 array.
- Synchronous write port (we, waddr, wdata).
- Registered read port (re, raddr, rdata) with write-first-across-cycles semantics.
- No reset on the array.

Top level:
- Holds the decoder, pointers, valid flags, tx_valid/err pulse logic, and the dout register.

Test Plan:
1. Reset, then WR_ADDR 0x10, WR_DATA 0xA5, RD_ADDR 0x10, RD_DATA -> tx_valid pulses one cycle after the RD_DATA strobe, dout = 0xA5, err never set.
2. WR_ADDR 0xFE, WR_DATA 0x11, 0x22, 0x33, then RD_ADDR 0xFE, RD_DATA x3 -> dout sequence 0x11, 0x22, 0x33, with the third from address 0x00 (wrap).
3. After reset, WR_DATA 0x55 then RD_DATA -> two err pulses, no tx_valid, memory unchanged (later readback of address 0 does not return 0x55 unless written).
4. MEM_DEPTH = 128: WR_ADDR 0x80 -> err pulse, wr_vld stays 0; WR_ADDR 0x7F then WR_DATA 0x3C then RD_ADDR 0x7F, RD_DATA -> dout = 0x3C.
5. rx_valid held high 4 cycles with RD_ADDR 0x20, RD_DATA, RD_DATA, RD_DATA (mem[0x20..0x22] = 1, 2, 3) -> tx_valid high 3 consecutive cycles, dout = 1, 2, 3.
6. Issue RD_DATA, then assert rst on the next edge -> tx_valid = 0 in the reset cycle, dout = 0; a following RD_DATA raises err until RD_ADDR is reissued.
